// File: rtl/branch_resolve_if.sv
// Op-offer handshake bundle between the issue stage and branch_resolve.
// The issuing side uses the master modport; branch_resolve uses the slave modport.
interface branch_resolve_if #(
    parameter int XLEN = 32
);
    logic            op_valid_i;
    logic            op_ready_o;
    logic [2:0]      funct3_i;
    logic            jal_i;
    logic            jalr_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] rs1_i;
    logic            pred_taken_i;
    logic [XLEN-1:0] pred_target_i;

    modport master (
        output op_valid_i, funct3_i, jal_i, jalr_i, pc_i, imm_i, rs1_i,
               pred_taken_i, pred_target_i,
        input  op_ready_o
    );

    modport slave (
        input  op_valid_i, funct3_i, jal_i, jalr_i, pc_i, imm_i, rs1_i,
               pred_taken_i, pred_target_i,
        output op_ready_o
    );
endinterface

// File: rtl/branch_resolve.sv
// Execute-stage branch/jump resolution unit.
// Registers one control-transfer op, drives the compare adder controls from it,
// resolves direction/target, and on mispredict issues a held redirect followed
// by a fixed-length flush. Optional resolve/mispredict counters are built only
// when BRANCH_STATS_EN is defined.
module branch_resolve #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    branch_resolve_if.slave   op,
    output logic              adder_sub_o,
    output logic [5:0]        adder_sel_o,
    input  logic              adder_result_i,
    output logic              redirect_valid_o,
    output logic [XLEN-1:0]   redirect_pc_o,
    input  logic              redirect_ready_i,
    output logic              flush_o,
    output logic              link_valid_o,
    output logic [XLEN-1:0]   link_data_o,
    output logic              misalign_o,
    output logic              resolved_o,
    output logic [31:0]       stat_branches_o,
    output logic [31:0]       stat_mispred_o
);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] FLUSH_LD = CW'(FLUSH_CYCLES);

    typedef enum logic [1:0] {IDLE, EVAL, REDIRECT, FLUSH} state_t;

    typedef struct packed {
        logic [2:0]      funct3;
        logic            jal;
        logic            jalr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rs1;
        logic            pred_taken;
        logic [XLEN-1:0] pred_target;
    } op_t;

    state_t          state_q, state_d;
    op_t             op_q;
    logic [XLEN-1:0] redir_pc_q;
    logic [CW-1:0]   flush_cnt_q;

    logic            is_jump;
    logic [5:0]      cond_sel;
    logic            taken;
    logic [XLEN-1:0] target_raw, target, pc_plus4, next_pc;
    logic            mispredict, misalign_hit;

    // Condition decode: one-hot select for the adder; invalid funct3 selects nothing.
    always_comb begin
        cond_sel = 6'b000000;
        case (op_q.funct3)
            3'b000:  cond_sel = 6'b000001; // BEQ
            3'b001:  cond_sel = 6'b000010; // BNE
            3'b110:  cond_sel = 6'b000100; // BLTU
            3'b111:  cond_sel = 6'b001000; // BGEU
            3'b100:  cond_sel = 6'b010000; // BLT
            3'b101:  cond_sel = 6'b100000; // BGE
            default: cond_sel = 6'b000000;
        endcase
    end

    assign is_jump      = op_q.jal | op_q.jalr;
    // Unselected (invalid) conditions resolve as not taken regardless of the adder.
    assign taken        = is_jump | ((|cond_sel) & adder_result_i);
    assign target_raw   = (op_q.jalr ? op_q.rs1 : op_q.pc) + op_q.imm;
    assign target       = op_q.jalr ? (target_raw & ~XLEN'(1)) : target_raw;
    assign pc_plus4     = op_q.pc + XLEN'(4);
    assign next_pc      = taken ? target : pc_plus4;
    assign mispredict   = (taken != op_q.pred_taken) |
                          (taken & (op_q.pred_target != target));
    assign misalign_hit = taken & (target[1:0] != 2'b00);

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (op.op_valid_i) state_d = EVAL;
            EVAL: begin
                if (misalign_hit)    state_d = IDLE;
                else if (mispredict) state_d = REDIRECT;
                else                 state_d = IDLE;
            end
            REDIRECT: if (redirect_ready_i) state_d = FLUSH;
            FLUSH:    if (flush_cnt_q <= CW'(1)) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output decode; everything resolution-related is only live in EVAL.
    always_comb begin
        op.op_ready_o    = 1'b0;
        adder_sub_o      = 1'b0;
        adder_sel_o      = 6'b000000;
        resolved_o       = 1'b0;
        link_valid_o     = 1'b0;
        link_data_o      = '0;
        misalign_o       = 1'b0;
        redirect_valid_o = 1'b0;
        flush_o          = 1'b0;
        case (state_q)
            IDLE: op.op_ready_o = 1'b1;
            EVAL: begin
                if (!is_jump) begin
                    adder_sub_o = |cond_sel;
                    adder_sel_o = cond_sel;
                end
                resolved_o   = 1'b1;
                link_valid_o = is_jump;
                link_data_o  = is_jump ? pc_plus4 : '0;
                misalign_o   = misalign_hit;
            end
            REDIRECT: redirect_valid_o = 1'b1;
            FLUSH:    flush_o = 1'b1;
            default:  ;
        endcase
    end

    assign redirect_pc_o = redir_pc_q;

    // Op capture, redirect PC latch and flush countdown.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            op_q        <= '0;
            redir_pc_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (state_q == IDLE && op.op_valid_i) begin
                op_q.funct3      <= op.funct3_i;
                op_q.jal         <= op.jal_i;
                op_q.jalr        <= op.jalr_i;
                op_q.pc          <= op.pc_i;
                op_q.imm         <= op.imm_i;
                op_q.rs1         <= op.rs1_i;
                op_q.pred_taken  <= op.pred_taken_i;
                op_q.pred_target <= op.pred_target_i;
            end
            if (state_q == EVAL && state_d == REDIRECT)
                redir_pc_q <= next_pc;
            if (state_q == REDIRECT && redirect_ready_i)
                flush_cnt_q <= FLUSH_LD;
            else if (state_q == FLUSH && flush_cnt_q != '0)
                flush_cnt_q <= flush_cnt_q - CW'(1);
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q, stat_mp_q;

    // Saturating resolve and mispredict counters.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (resolved_o && stat_br_q != 32'hFFFF_FFFF)
                stat_br_q <= stat_br_q + 32'd1;
            if (state_q == EVAL && state_d == REDIRECT && stat_mp_q != 32'hFFFF_FFFF)
                stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    assign stat_branches_o = stat_br_q;
    assign stat_mispred_o  = stat_mp_q;
`else
    assign stat_branches_o = '0;
    assign stat_mispred_o  = '0;
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed cases plus randomized ops
// compared against a transaction-level reference model. The bench plays both
// the upstream issue stage and the compare adder.
module tb_branch_resolve;
    localparam int XLEN = 32;
    localparam int FC   = 2;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              adder_sub_o;
    logic [5:0]        adder_sel_o;
    logic              adder_result_i;
    logic              redirect_valid_o;
    logic [XLEN-1:0]   redirect_pc_o;
    logic              redirect_ready_i;
    logic              flush_o;
    logic              link_valid_o;
    logic [XLEN-1:0]   link_data_o;
    logic              misalign_o;
    logic              resolved_o;
    logic [31:0]       stat_branches_o;
    logic [31:0]       stat_mispred_o;

    int n_tests = 0;
    int n_fail  = 0;
    int m_branches = 0;
    int m_mispred  = 0;

    branch_resolve_if #(.XLEN(XLEN)) bif ();

    branch_resolve #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .op               (bif.slave),
        .adder_sub_o      (adder_sub_o),
        .adder_sel_o      (adder_sel_o),
        .adder_result_i   (adder_result_i),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_ready_i (redirect_ready_i),
        .flush_o          (flush_o),
        .link_valid_o     (link_valid_o),
        .link_data_o      (link_data_o),
        .misalign_o       (misalign_o),
        .resolved_o       (resolved_o),
        .stat_branches_o  (stat_branches_o),
        .stat_mispred_o   (stat_mispred_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference condition-to-select table.
    function automatic logic [5:0] ref_sel(input logic [2:0] f3);
        case (f3)
            3'd0: return 6'd1;
            3'd1: return 6'd2;
            3'd6: return 6'd4;
            3'd7: return 6'd8;
            3'd4: return 6'd16;
            3'd5: return 6'd32;
            default: return 6'd0;
        endcase
    endfunction

    task automatic idle_inputs();
        bif.op_valid_i    = 1'b0;
        bif.funct3_i      = '0;
        bif.jal_i         = 1'b0;
        bif.jalr_i        = 1'b0;
        bif.pc_i          = '0;
        bif.imm_i         = '0;
        bif.rs1_i         = '0;
        bif.pred_taken_i  = 1'b0;
        bif.pred_target_i = '0;
        adder_result_i    = 1'b0;
        redirect_ready_i  = 1'b0;
    endtask

    // Issue one op, play the adder, and follow the redirect/flush sequence.
    task automatic do_op(input logic [2:0] f3, input logic jal, input logic jalr,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic pt, input logic [31:0] ptgt,
                         input logic ares, input int delay);
        logic        is_jump, cond_ok, tk, mis, mp;
        logic [31:0] tgt, npc;
        is_jump = jal | jalr;
        cond_ok = (ref_sel(f3) != 0);
        tk  = is_jump ? 1'b1 : (cond_ok ? ares : 1'b0);
        tgt = jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
        npc = tk ? tgt : pc + 32'd4;
        mis = tk && (tgt % 4 != 0);
        mp  = (tk != pt) || (tk && ptgt != tgt);

        @(negedge clk_i);
        chk("op_ready_idle", bif.op_ready_o, 1);
        bif.op_valid_i = 1'b1; bif.funct3_i = f3; bif.jal_i = jal; bif.jalr_i = jalr;
        bif.pc_i = pc; bif.imm_i = imm; bif.rs1_i = rs1;
        bif.pred_taken_i = pt; bif.pred_target_i = ptgt;

        @(negedge clk_i);
        idle_inputs();
        adder_result_i = ares;
        #1;
        chk("eval_ready", bif.op_ready_o, 0);
        chk("adder_sub", adder_sub_o, (!is_jump && cond_ok) ? 1 : 0);
        chk("adder_sel", adder_sel_o, is_jump ? 6'd0 : ref_sel(f3));
        chk("resolved", resolved_o, 1);
        chk("link_valid", link_valid_o, is_jump);
        if (is_jump) chk("link_data", link_data_o, pc + 32'd4);
        chk("misalign", misalign_o, mis);
        m_branches++;

        if (!mis && mp) begin
            m_mispred++;
            for (int c = 0; c <= delay; c++) begin
                @(negedge clk_i);
                adder_result_i = 1'b0;
                chk("redir_valid", redirect_valid_o, 1);
                chk("redir_pc", redirect_pc_o, npc);
                chk("redir_flush", flush_o, 0);
                if (c == delay) redirect_ready_i = 1'b1;
            end
            for (int f = 0; f < FC; f++) begin
                @(negedge clk_i);
                redirect_ready_i = 1'b0;
                chk("flush_on", flush_o, 1);
                chk("flush_redir", redirect_valid_o, 0);
            end
            @(negedge clk_i);
            chk("flush_off", flush_o, 0);
            chk("post_flush_ready", bif.op_ready_o, 1);
        end else begin
            @(negedge clk_i);
            adder_result_i = 1'b0;
            chk("no_redir", redirect_valid_o, 0);
            chk("ready_back", bif.op_ready_o, 1);
        end
    endtask

    task automatic chk_stats(input string tag);
`ifdef BRANCH_STATS_EN
        chk({tag, "_br"}, stat_branches_o, m_branches);
        chk({tag, "_mp"}, stat_mispred_o, m_mispred);
`else
        chk({tag, "_br"}, stat_branches_o, 0);
        chk({tag, "_mp"}, stat_mispred_o, 0);
`endif
    endtask

    initial begin
        idle_inputs();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_ready", bif.op_ready_o, 1);
        chk("rst_redir", redirect_valid_o, 0);
        chk("rst_redir_pc", redirect_pc_o, 0);
        chk("rst_flush", flush_o, 0);
        chk("rst_resolved", resolved_o, 0);
        chk("rst_sel", adder_sel_o, 0);
        chk_stats("rst_stats");
        rst_ni = 1'b1;

        // Directed cases.
        do_op(3'b000, 0, 0, 32'h100, 32'h20, 0, 1, 32'h120, 1, 0);         // BEQ correct
        do_op(3'b110, 0, 0, 32'h200, 32'h40, 0, 1, 32'h240, 0, 3);         // BLTU mispredict
        do_op(3'b000, 0, 1, 32'h300, 32'h4, 32'h1003, 0, 0, 0, 0);         // JALR misaligned
        do_op(3'b000, 1, 0, 32'hFFFF_FFF0, 32'h20, 0, 1, 32'h10, 0, 0);    // JAL wrap
        do_op(3'b010, 0, 0, 32'h400, 32'h8, 0, 1, 32'h408, 1, 0);          // invalid f3
        do_op(3'b100, 0, 0, 32'h500, 32'h10, 0, 0, 0, 1, 0);               // BLT one-cycle redirect
        chk_stats("dir_stats");

        // Reset during the second REDIRECT cycle.
        @(negedge clk_i);
        bif.op_valid_i = 1'b1; bif.funct3_i = 3'b110; bif.pc_i = 32'h200;
        bif.imm_i = 32'h40; bif.pred_taken_i = 1'b1; bif.pred_target_i = 32'h240;
        @(negedge clk_i);
        idle_inputs();
        @(negedge clk_i);
        chk("rr_redir1", redirect_valid_o, 1);
        @(negedge clk_i);
        chk("rr_redir2", redirect_valid_o, 1);
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("rr_redir_off", redirect_valid_o, 0);
        chk("rr_flush_off", flush_o, 0);
        chk("rr_ready", bif.op_ready_o, 1);
        rst_ni = 1'b1;
        m_branches = 0; m_mispred = 0;
        chk_stats("rr_stats");
        redirect_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("rr_no_redir", redirect_valid_o, 0);
            chk("rr_no_flush", flush_o, 0);
        end
        redirect_ready_i = 1'b0;

        // Randomized ops.
        for (int n = 0; n < 300; n++) begin
            logic [2:0]  f3;
            logic        jal, jalr, pt;
            logic [31:0] pc, imm, rs1, ptgt, good;
            int          kind;
            f3   = 3'($urandom_range(0, 7));
            kind = $urandom_range(0, 7);
            jal  = (kind == 0);
            jalr = (kind == 1);
            pc   = $urandom & 32'hFFFF_FFFC;
            imm  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
            rs1  = $urandom;
            if ($urandom_range(0, 3) != 0) rs1 = rs1 & 32'hFFFF_FFFC;
            pt   = 1'($urandom_range(0, 1));
            good = jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
            ptgt = ($urandom_range(0, 2) != 0) ? good : ($urandom & 32'hFFFF_FFFC);
            do_op(f3, jal, jalr, pc, imm, rs1, pt, ptgt, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3));
        end
        chk_stats("rand_stats");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
